// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART with optional 16-deep FIFOs per direction.
// Bit time is BAUDRATE clocks. The receive path re-times the asynchronous line
// through two flops and samples each bit near its centre.
`timescale 1ns/100ps

// uart_fifo: 16x8 circular buffer with registered empty/full flags.
module uart_fifo (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       empty,
    output logic       full
);
    logic [7:0] mem_r [16];
    logic [3:0] wr_ptr_r;
    logic [3:0] rd_ptr_r;
    logic [4:0] count_r;
    logic       empty_r;
    logic       full_r;
    logic       do_push_s;
    logic       do_pop_s;
    logic [4:0] count_next_s;

    // Qualify requests; a pop frees a slot, so push-while-full is accepted with a pop.
    always_comb begin
        do_pop_s     = pop && (count_r != 5'd0);
        do_push_s    = push && ((count_r != 5'd16) || do_pop_s);
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + 5'd1;
        end else if (!do_push_s && do_pop_s) begin
            count_next_s = count_r - 5'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, fill count and the flags derived from the next count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= 4'd0;
            rd_ptr_r <= 4'd0;
            count_r  <= 5'd0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 4'd1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 4'd1;
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == 5'd0);
            full_r  <= (count_next_s == 5'd16);
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = empty_r;
    assign full      = full_r;
endmodule

module uart_transceiver #(
    parameter int BAUDRATE     = 1250,
    parameter int TX_FIFO_MODE = 0,
    parameter int RX_FIFO_MODE = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_data_valid,
    output logic       o_tx_serial,
    output logic       o_tx_ready,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_data,
    output logic       o_rx_data_valid
);
    localparam logic [15:0] BIT_LAST  = 16'(BAUDRATE - 1);
    localparam logic [15:0] HALF_LAST = 16'((BAUDRATE / 2) - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    // ---------------- transmit path ----------------
    tx_state_t   tx_state_r;
    logic [15:0] tx_timer_r;
    logic [2:0]  tx_idx_r;
    logic [7:0]  tx_shift_r;
    logic        tx_serial_r;
    logic [7:0]  tx_hold_r;
    logic        tx_hold_valid_r;
    logic        tx_idle_ready_r;
    logic        tx_load_s;
    logic [7:0]  tx_load_data_s;
    logic        tx_ready_s;

    // The holding register feeds the FSM; it is filled either directly or from the FIFO head.
    if (TX_FIFO_MODE != 0) begin : g_tx_fifo
        logic [7:0] head_s;
        logic       empty_s;
        logic       full_s;
        uart_fifo u_tx_fifo (
            .clk       (clk),
            .resetn    (resetn),
            .push      (i_tx_data_valid && tx_ready_s),
            .push_data (i_tx_data),
            .pop       (tx_load_s),
            .head_data (head_s),
            .empty     (empty_s),
            .full      (full_s)
        );
        assign tx_load_s      = !tx_hold_valid_r && !empty_s;
        assign tx_load_data_s = head_s;
        assign tx_ready_s     = !full_s;
    end else begin : g_tx_direct
        assign tx_load_s      = i_tx_data_valid && tx_idle_ready_r;
        assign tx_load_data_s = i_tx_data;
        assign tx_ready_s     = tx_idle_ready_r;
    end

    // TX FSM: start, 8 data bits LSB first, stop; chains straight into the next held byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_r      <= TX_IDLE;
            tx_timer_r      <= 16'd0;
            tx_idx_r        <= 3'd0;
            tx_shift_r      <= 8'h00;
            tx_serial_r     <= 1'b1;
            tx_hold_r       <= 8'h00;
            tx_hold_valid_r <= 1'b0;
            tx_idle_ready_r <= 1'b1;
        end else begin
            if (tx_load_s) begin
                tx_hold_r       <= tx_load_data_s;
                tx_hold_valid_r <= 1'b1;
                tx_idle_ready_r <= 1'b0;
            end
            case (tx_state_r)
                TX_IDLE: begin
                    tx_timer_r <= 16'd0;
                    if (tx_hold_valid_r) begin
                        tx_state_r      <= TX_START;
                        tx_shift_r      <= tx_hold_r;
                        tx_hold_valid_r <= 1'b0;
                        tx_serial_r     <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_timer_r == BIT_LAST) begin
                        tx_state_r  <= TX_DATA;
                        tx_timer_r  <= 16'd0;
                        tx_idx_r    <= 3'd0;
                        tx_serial_r <= tx_shift_r[0];
                    end else begin
                        tx_timer_r <= tx_timer_r + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_timer_r == BIT_LAST) begin
                        tx_timer_r <= 16'd0;
                        if (tx_idx_r == 3'd7) begin
                            tx_state_r  <= TX_STOP;
                            tx_serial_r <= 1'b1;
                        end else begin
                            tx_idx_r    <= tx_idx_r + 3'd1;
                            tx_shift_r  <= {1'b0, tx_shift_r[7:1]};
                            tx_serial_r <= tx_shift_r[1];
                        end
                    end else begin
                        tx_timer_r <= tx_timer_r + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_timer_r == BIT_LAST) begin
                        tx_timer_r <= 16'd0;
                        if (tx_hold_valid_r) begin
                            tx_state_r      <= TX_START;
                            tx_shift_r      <= tx_hold_r;
                            tx_hold_valid_r <= 1'b0;
                            tx_serial_r     <= 1'b0;
                        end else begin
                            tx_state_r      <= TX_IDLE;
                            tx_idle_ready_r <= 1'b1;
                        end
                    end else begin
                        tx_timer_r <= tx_timer_r + 16'd1;
                    end
                end
                default: begin
                    tx_state_r  <= TX_IDLE;
                    tx_serial_r <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx_serial = tx_serial_r;
    assign o_tx_ready  = tx_ready_s;

    // ---------------- receive path ----------------
    rx_state_t   rx_state_r;
    logic [15:0] rx_timer_r;
    logic [2:0]  rx_idx_r;
    logic [7:0]  rx_shift_r;
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    logic        rx_stop_ok_s;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx_serial;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // A good stop bit is seen on this edge; the byte is delivered by the same edge.
    always_comb begin
        rx_stop_ok_s = (rx_state_r == RX_STOP) && (rx_timer_r == BIT_LAST) && rx_sync_r;
    end

    // RX FSM: mid-bit start qualification, then one sample per bit time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_r <= RX_IDLE;
            rx_timer_r <= 16'd0;
            rx_idx_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    rx_timer_r <= 16'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_timer_r == HALF_LAST) begin
                        rx_timer_r <= 16'd0;
                        rx_idx_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_timer_r <= rx_timer_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_timer_r == BIT_LAST) begin
                        rx_timer_r <= 16'd0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        rx_idx_r   <= rx_idx_r + 3'd1;
                        if (rx_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end
                    end else begin
                        rx_timer_r <= rx_timer_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_timer_r == BIT_LAST) begin
                        rx_timer_r <= 16'd0;
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_timer_r <= rx_timer_r + 16'd1;
                    end
                end
                RX_WAIT: begin
                    rx_timer_r <= 16'd0;
                    if (rx_sync_r) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    // Delivery: either straight to the output register or through a FIFO drained one per cycle.
    if (RX_FIFO_MODE != 0) begin : g_rx_fifo
        logic [7:0] head_s;
        logic       empty_s;
        logic       full_s;
        uart_fifo u_rx_fifo (
            .clk       (clk),
            .resetn    (resetn),
            .push      (rx_stop_ok_s),
            .push_data (rx_shift_r),
            .pop       (!empty_s),
            .head_data (head_s),
            .empty     (empty_s),
            .full      (full_s)
        );
        // Output register loaded from the FIFO head whenever an entry is waiting.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rx_data_r  <= 8'h00;
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= !empty_s;
                if (!empty_s) begin
                    rx_data_r <= head_s;
                end
            end
        end
    end else begin : g_rx_direct
        // Output register loaded directly on a good stop bit.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rx_data_r  <= 8'h00;
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_stop_ok_s;
                if (rx_stop_ok_s) begin
                    rx_data_r <= rx_shift_r;
                end
            end
        end
    end

    assign o_rx_data       = rx_data_r;
    assign o_rx_data_valid = rx_valid_r;
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: FIFO loopback across two skewed clocks,
// non-FIFO transmit timing, receive glitch/framing/skew cases, async reset mid-frame.
`timescale 1ns/100ps

module tb_uart_transceiver;
    localparam int B = 16;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    always #5   clk_a = ~clk_a;
    always #5.1 clk_b = ~clk_b;

    logic       resetn;
    logic       rst_c_n;
    logic [7:0] a_tx_data;
    logic       a_tx_valid;
    logic       a_tx_ser, a_tx_rdy, a_rx_valid;
    logic [7:0] a_rx_data;
    logic       b_tx_ser, b_tx_rdy, b_rx_valid;
    logic [7:0] b_rx_data;
    logic [7:0] c_tx_data;
    logic       c_tx_valid;
    logic       c_tx_ser, c_tx_rdy, c_rx_valid;
    logic [7:0] c_rx_data;
    logic       line_c;

    uart_transceiver #(.BAUDRATE(B), .TX_FIFO_MODE(1), .RX_FIFO_MODE(1)) u_a (
        .clk(clk_a), .resetn(resetn), .i_tx_data(a_tx_data), .i_tx_data_valid(a_tx_valid),
        .o_tx_serial(a_tx_ser), .o_tx_ready(a_tx_rdy), .i_rx_serial(1'b1),
        .o_rx_data(a_rx_data), .o_rx_data_valid(a_rx_valid));

    uart_transceiver #(.BAUDRATE(B), .TX_FIFO_MODE(1), .RX_FIFO_MODE(1)) u_b (
        .clk(clk_b), .resetn(resetn), .i_tx_data(8'h00), .i_tx_data_valid(1'b0),
        .o_tx_serial(b_tx_ser), .o_tx_ready(b_tx_rdy), .i_rx_serial(a_tx_ser),
        .o_rx_data(b_rx_data), .o_rx_data_valid(b_rx_valid));

    uart_transceiver #(.BAUDRATE(B), .TX_FIFO_MODE(0), .RX_FIFO_MODE(0)) u_c (
        .clk(clk_a), .resetn(rst_c_n), .i_tx_data(c_tx_data), .i_tx_data_valid(c_tx_valid),
        .o_tx_serial(c_tx_ser), .o_tx_ready(c_tx_rdy), .i_rx_serial(line_c),
        .o_rx_data(c_rx_data), .o_rx_data_valid(c_rx_valid));

    int unsigned cyc_a = 0;
    always @(posedge clk_a) cyc_a <= cyc_a + 1;

    logic [7:0] q_b [$];
    always @(negedge clk_b) if (b_rx_valid) q_b.push_back(b_rx_data);

    int         c_cnt = 0;
    logic [7:0] c_last = 8'h00;
    always @(negedge clk_a) if (c_rx_valid) begin
        c_cnt  <= c_cnt + 1;
        c_last <= c_rx_data;
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic until_a(input int unsigned target);
        while (cyc_a < target) @(negedge clk_a);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input realtime bit_t);
        line_c = 1'b0;
        #(bit_t);
        for (int k = 0; k < 8; k++) begin
            line_c = d[k];
            #(bit_t);
        end
        line_c = stop_bit;
        #(bit_t);
        line_c = 1'b1;
    endtask

    // Accept one byte on C, sample each bit mid-period and ready around frame end.
    task automatic c_tx(input logic [7:0] d, output logic [9:0] bits, output logic rdy_acc,
                        output logic ser_acc, output logic rdy_pre, output logic rdy_post);
        int unsigned n;
        @(negedge clk_a);
        c_tx_data  = d;
        c_tx_valid = 1'b1;
        @(negedge clk_a);
        c_tx_valid = 1'b0;
        rdy_acc    = c_tx_rdy;
        ser_acc    = c_tx_ser;
        n = cyc_a;
        for (int k = 0; k < 10; k++) begin
            until_a(n + 1 + k * B + B / 2);
            bits[k] = c_tx_ser;
        end
        until_a(n + 10 * B);
        rdy_pre = c_tx_rdy;
        until_a(n + 10 * B + 1);
        rdy_post = c_tx_rdy;
    endtask

    logic [7:0]  lb [8];
    logic [9:0]  bits;
    logic        r_acc, s_acc, r_pre, r_post;
    logic [79:0] obs80, exp80;
    logic [7:0]  acc_q [$];
    int          cnt0, waited;
    int unsigned n0;
    logic        first16, seen_low;

    initial begin
        lb = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'hC3};
        resetn = 1'b0; rst_c_n = 1'b0;
        a_tx_data = 8'h00; a_tx_valid = 1'b0;
        c_tx_data = 8'h00; c_tx_valid = 1'b0;
        line_c = 1'b1;
        repeat (3) @(negedge clk_a);
        chk("rst_a_ser", a_tx_ser, 1'b1);
        chk("rst_a_rdy", a_tx_rdy, 1'b1);
        chk("rst_b_data", b_rx_data, 8'h00);
        chk("rst_b_valid", b_rx_valid, 1'b0);
        chk("rst_c_ser", c_tx_ser, 1'b1);
        chk("rst_c_rdy", c_tx_rdy, 1'b1);
        chk("rst_c_data", c_rx_data, 8'h00);
        chk("rst_c_valid", c_rx_valid, 1'b0);
        resetn = 1'b1; rst_c_n = 1'b1;
        repeat (3) @(negedge clk_a);

        // Non-FIFO transmit of 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        c_tx(8'hA5, bits, r_acc, s_acc, r_pre, r_post);
        chk("a5_rdy_after_accept", r_acc, 1'b0);
        chk("a5_ser_after_accept", s_acc, 1'b1);
        chk("a5_frame", bits, 10'b1101001010);
        chk("a5_rdy_before_end", r_pre, 1'b0);
        chk("a5_rdy_at_end", r_post, 1'b1);

        // Glitch of B/4 clocks: no byte.
        cnt0 = c_cnt;
        @(negedge clk_a);
        line_c = 1'b0;
        #(B / 4 * 10);
        line_c = 1'b1;
        repeat (3 * B) @(negedge clk_a);
        chk("glitch_no_valid", c_cnt, cnt0);

        // Framing error, then a good 0x3C.
        drive_frame(8'h00, 1'b0, 160.0);
        repeat (2 * B) @(negedge clk_a);
        chk("framing_no_valid", c_cnt, cnt0);
        drive_frame(8'h3C, 1'b1, 160.0);
        repeat (B) @(negedge clk_a);
        chk("after_frerr_cnt", c_cnt, cnt0 + 1);
        chk("after_frerr_data", c_last, 8'h3C);

        // 0x96 with sender 2% slow, then 2% fast.
        drive_frame(8'h96, 1'b1, 163.2);
        repeat (B) @(negedge clk_a);
        chk("skew_slow_cnt", c_cnt, cnt0 + 2);
        chk("skew_slow_data", c_last, 8'h96);
        drive_frame(8'h69, 1'b1, 156.8);
        repeat (B) @(negedge clk_a);
        chk("skew_fast_cnt", c_cnt, cnt0 + 3);
        chk("skew_fast_data", c_last, 8'h69);

        // Async reset in the middle of a frame.
        @(negedge clk_a);
        c_tx_data = 8'h00; c_tx_valid = 1'b1;
        @(negedge clk_a);
        c_tx_valid = 1'b0;
        repeat (3 * B) @(negedge clk_a);
        chk("midframe_low", c_tx_ser, 1'b0);
        #2 rst_c_n = 1'b0;
        #1;
        chk("rst_mid_ser", c_tx_ser, 1'b1);
        chk("rst_mid_rdy", c_tx_rdy, 1'b1);
        chk("rst_mid_rxdata", c_rx_data, 8'h00);
        @(negedge clk_a);
        rst_c_n = 1'b1;
        repeat (2) @(negedge clk_a);
        c_tx(8'h3C, bits, r_acc, s_acc, r_pre, r_post);
        chk("post_rst_frame", bits, 10'b1001111000);

        // FIFO loopback A -> B, 8 writes on consecutive cycles.
        q_b.delete();
        n0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_a);
            if (i == 0) n0 = cyc_a + 1;
            if (i == 2) chk("fifo_lat_high", a_tx_ser, 1'b1);
            if (i == 3) chk("fifo_lat_start", a_tx_ser, 1'b0);
            a_tx_data = lb[i]; a_tx_valid = 1'b1;
        end
        @(negedge clk_a);
        a_tx_valid = 1'b0;
        for (int f = 0; f < 8; f++) exp80[f * 10 +: 10] = {1'b1, lb[f], 1'b0};
        for (int j = 0; j < 80; j++) begin
            until_a(n0 + 2 + j * B + B / 2);
            obs80[j] = a_tx_ser;
        end
        chk("loop_line_b2b", obs80, exp80);
        waited = 0;
        while (q_b.size() < 8 && waited < 4 * B) begin
            @(negedge clk_a);
            waited++;
        end
        chk("loop_rx_count", q_b.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("loop_rx_%0d", i), (i < q_b.size()) ? q_b[i] : 8'hxx, lb[i]);

        // Overfill the TX FIFO with 20 consecutive writes.
        repeat (2 * B) @(negedge clk_a);
        q_b.delete();
        first16 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_a);
            if (a_tx_rdy) acc_q.push_back(8'(8'h10 + i));
            if (i < 16 && !a_tx_rdy) first16 = 1'b0;
            a_tx_data = 8'(8'h10 + i); a_tx_valid = 1'b1;
        end
        @(negedge clk_a);
        a_tx_valid = 1'b0;
        seen_low = ~a_tx_rdy;
        chk("full_first16_accepted", first16, 1'b1);
        chk("full_ready_low", seen_low, 1'b1);
        waited = 0;
        while (q_b.size() < acc_q.size() && waited < (acc_q.size() + 2) * 10 * B) begin
            @(negedge clk_a);
            waited++;
        end
        repeat (3 * B) @(negedge clk_a);
        chk("full_rx_count", q_b.size(), acc_q.size());
        obs80 = '0;
        for (int i = 0; i < acc_q.size() && i < q_b.size(); i++) obs80[0] = obs80[0] | (q_b[i] !== acc_q[i]);
        chk("full_rx_order", obs80, 80'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
